ula_74181_serial: RTL and testbench

Parametrised, nibble-serial successor to the 8-bit two-slice ALU. Operands of WIDTH bits are processed one 4-bit 74181-style slice per clock through a single slice datapath, with the carry registered between nibbles. This replaces the combinational special-case carry fix with a true ripple through a register. The block sits behind a valid/ready handshake so a controller can issue wide ALU operations without instantiating WIDTH/4 slices.

---
 rtl/ula_74181_serial.sv | 173 +++++++++++++++++
 tb/tb_ula_74181_serial.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ula_74181_serial.sv
// Nibble-serial 74181-style ALU: one 4-bit slice per clock, carry rippled through a register.
// Optional define ULA_SERIAL_OVF_EN enables signed-overflow detection on the MSB nibble.
module ula_74181_serial #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  input  logic             m,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             c_out,
  output logic             a_eq_b,
  output logic             ovf
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, b_q;
  logic [3:0]         s_q;
  logic               m_q;
  logic               carry_q;
  logic               eq_q;
  logic [IDX_W-1:0]   idx_q;
  logic [3:0]         a_nib, b_nib, nib_f;
  logic               nib_c;
  logic               last;
  logic               accept;

  // 74181 arithmetic is X + Y + cin, with X and Y selected bitwise by s.
  function automatic logic [3:0] gen_x(input logic [3:0] xa, input logic [3:0] xb,
                                       input logic [3:0] sel);
    return xa | (xb & {4{sel[0]}}) | (~xb & {4{sel[1]}});
  endfunction

  function automatic logic [3:0] gen_y(input logic [3:0] xa, input logic [3:0] xb,
                                       input logic [3:0] sel);
    return (xa & ~xb & {4{sel[2]}}) | (xa & xb & {4{sel[3]}});
  endfunction

  function automatic logic [4:0] slice_181(input logic [3:0] xa, input logic [3:0] xb,
                                           input logic [3:0] sel, input logic mode,
                                           input logic cin);
    logic [3:0] lf;
    logic [4:0] sum;
    lf  = 4'h0;
    sum = {1'b0, gen_x(xa, xb, sel)} + {1'b0, gen_y(xa, xb, sel)} + {4'b0, cin};
    if (mode) begin
      case (sel)
        4'b0000: lf = ~xa;
        4'b0001: lf = ~(xa | xb);
        4'b0010: lf = ~xa & xb;
        4'b0011: lf = 4'h0;
        4'b0100: lf = ~(xa & xb);
        4'b0101: lf = ~xb;
        4'b0110: lf = xa ^ xb;
        4'b0111: lf = xa & ~xb;
        4'b1000: lf = ~xa | xb;
        4'b1001: lf = ~(xa ^ xb);
        4'b1010: lf = xb;
        4'b1011: lf = xa & xb;
        4'b1100: lf = 4'hF;
        4'b1101: lf = xa | ~xb;
        4'b1110: lf = xa | xb;
        default: lf = xa;
      endcase
      return {1'b0, lf};
    end
    return sum;
  endfunction

  assign accept    = in_valid & in_ready;
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign last      = (idx_q == IDX_W'(N - 1));

  always_comb begin
    a_nib = 4'h0;
    b_nib = 4'h0;
    for (int i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[4*i +: 4];
        b_nib = b_q[4*i +: 4];
      end
    end
  end

  assign {nib_c, nib_f} = slice_181(a_nib, b_nib, s_q, m_q, carry_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = RUN;
      RUN:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture: meaningful only once accepted, so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= a;
      b_q <= b;
      s_q <= s;
      m_q <= m;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      carry_q <= 1'b0;
      eq_q    <= 1'b0;
      idx_q   <= '0;
      f       <= '0;
      c_out   <= 1'b0;
      a_eq_b  <= 1'b0;
    end else if (accept) begin
      carry_q <= c_in;
      idx_q   <= '0;
      eq_q    <= 1'b1;
    end else if (state_q == RUN) begin
      for (int i = 0; i < N; i++) begin
        if (idx_q == IDX_W'(i)) f[4*i +: 4] <= nib_f;
      end
      carry_q <= nib_c;
      eq_q    <= eq_q & (nib_f == 4'hF);
      if (last) begin
        c_out  <= nib_c;
        a_eq_b <= eq_q & (nib_f == 4'hF);
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end
  end

`ifdef ULA_SERIAL_OVF_EN
  // Carry into the MSB comes from the low three bits of the last nibble's sum.
  function automatic logic msb_carry_in(input logic [3:0] xa, input logic [3:0] xb,
                                        input logic [3:0] sel, input logic cin);
    logic [3:0] x, y, sum3;
    x    = gen_x(xa, xb, sel);
    y    = gen_y(xa, xb, sel);
    sum3 = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'b0, cin};
    return sum3[3];
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      ovf <= 1'b0;
    else if (state_q == RUN && last)
      ovf <= ~m_q & (msb_carry_in(a_nib, b_nib, s_q, carry_q) ^ nib_c);
  end
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: tb/tb_ula_74181_serial.sv
// Randomised self-checking bench for ula_74181_serial at WIDTH=16 and WIDTH=8,
// against a whole-word behavioural model of the 74181 function table.
module tb_ula_74181_serial;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  s = 4'h0;
  logic        m = 1'b0, c_in = 1'b0;

  logic        iv16 = 1'b0, ir16, ov16, or16 = 1'b0, co16, eq16, of16;
  logic [15:0] a16 = '0, b16 = '0, f16;
  logic        iv8 = 1'b0, ir8, ov8, or8 = 1'b0, co8, eq8, of8;
  logic [7:0]  a8 = '0, b8 = '0, f8;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ula_74181_serial #(.WIDTH(16)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .s(s), .m(m), .c_in(c_in), .out_valid(ov16), .out_ready(or16), .f(f16),
    .c_out(co16), .a_eq_b(eq16), .ovf(of16));

  ula_74181_serial #(.WIDTH(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .s(s), .m(m), .c_in(c_in), .out_valid(ov8), .out_ready(or8), .f(f8),
    .c_out(co8), .a_eq_b(eq8), .ovf(of8));

  // Whole-word model: arithmetic mode is X + Y + cin with the datasheet terms.
  function automatic void model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                input logic [3:0] sv, input logic mv, input logic cv,
                                output logic [15:0] fo, output logic co,
                                output logic eo, output logic oo);
    int unsigned mask, A, B, nb, x, y, sum, hm, cm, lf;
    mask = (32'd1 << w) - 1;
    A = av & mask; B = bv & mask; nb = ~B & mask;
    hm = mask >> 1;
    x = 0; y = 0; lf = 0;
    if (mv) begin
      case (sv)
        4'd0:  lf = ~A;        4'd1:  lf = ~(A | B);
        4'd2:  lf = ~A & B;    4'd3:  lf = 0;
        4'd4:  lf = ~(A & B);  4'd5:  lf = ~B;
        4'd6:  lf = A ^ B;     4'd7:  lf = A & nb;
        4'd8:  lf = ~A | B;    4'd9:  lf = ~(A ^ B);
        4'd10: lf = B;         4'd11: lf = A & B;
        4'd12: lf = mask;      4'd13: lf = A | nb;
        4'd14: lf = A | B;     default: lf = A;
      endcase
      fo = 16'(lf & mask); co = 1'b0; oo = 1'b0;
    end else begin
      case (sv)
        4'd0:  begin x = A;      y = 0;    end
        4'd1:  begin x = A | B;  y = 0;    end
        4'd2:  begin x = A | nb; y = 0;    end
        4'd3:  begin x = mask;   y = 0;    end
        4'd4:  begin x = A;      y = A & nb; end
        4'd5:  begin x = A | B;  y = A & nb; end
        4'd6:  begin x = A;      y = nb;   end
        4'd7:  begin x = A & nb; y = mask; end
        4'd8:  begin x = A;      y = A & B; end
        4'd9:  begin x = A;      y = B;    end
        4'd10: begin x = A | nb; y = A & B; end
        4'd11: begin x = A & B;  y = mask; end
        4'd12: begin x = A;      y = A;    end
        4'd13: begin x = A | B;  y = A;    end
        4'd14: begin x = A | nb; y = A;    end
        default: begin x = A;    y = mask; end
      endcase
      sum = x + y + cv;
      fo = 16'(sum & mask);
      co = sum[w];
      cm = (x & hm) + (y & hm) + cv;
`ifdef ULA_SERIAL_OVF_EN
      oo = cm[w-1] ^ co;
`else
      oo = 1'b0;
`endif
    end
    eo = ((fo & mask) == mask);
  endfunction

  task automatic issue(input int w, input logic [15:0] av, input logic [15:0] bv,
                       input logic [3:0] sv, input logic mv, input logic cv,
                       output logic [15:0] fo, output logic co, output logic eo,
                       output logic oo, output int lat);
    @(negedge clk);
    s = sv; m = mv; c_in = cv;
    if (w == 16) begin a16 = av; b16 = bv; iv16 = 1'b1; end
    else begin a8 = av[7:0]; b8 = bv[7:0]; iv8 = 1'b1; end
    lat = 0;
    do begin
      @(posedge clk); lat++; #1;
      iv16 = 1'b0; iv8 = 1'b0;
    end while (!((w == 16) ? ov16 : ov8) && lat < 40);
    if (w == 16) begin fo = f16; co = co16; eo = eq16; oo = of16; end
    else begin fo = {8'h00, f8}; co = co8; eo = eq8; oo = of8; end
  endtask

  task automatic pop(input int w);
    if (w == 16) or16 = 1'b1; else or8 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0; or8 = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++; if (ir16 !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", ir16); end
    checks++; if (ov16 !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", ov16); end
    checks++; if (f16 !== 16'h0) begin errors++; $display("FAIL reset_f got %h want 0000", f16); end
    checks++; if (co16 !== 1'b0) begin errors++; $display("FAIL reset_c_out got %b want 0", co16); end
    checks++; if (eq16 !== 1'b0) begin errors++; $display("FAIL reset_a_eq_b got %b want 0", eq16); end
    checks++; if (of16 !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", of16); end
    checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid8 got %b want 0", ov8); end
  endtask

  task automatic test_add_carry;
    logic [15:0] fo; logic co, eo, oo; int lat;
    issue(16, 16'h00FF, 16'h0001, 4'b1001, 1'b0, 1'b0, fo, co, eo, oo, lat);
    checks++; if (fo !== 16'h0100) begin errors++; $display("FAIL add_f got %h want 0100", fo); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL add_c_out got %b want 0", co); end
    checks++; if (lat != 5) begin errors++; $display("FAIL add_latency got %0d want 5", lat); end
    pop(16);
  endtask

  task automatic test_dec_ripple;
    logic [15:0] fo; logic co, eo, oo; int lat;
    issue(8, 16'h0, 16'h0, 4'b0011, 1'b0, 1'b1, fo, co, eo, oo, lat);
    checks++; if (fo[7:0] !== 8'h00) begin errors++; $display("FAIL dec_f got %h want 00", fo[7:0]); end
    checks++; if (co !== 1'b1) begin errors++; $display("FAIL dec_c_out got %b want 1", co); end
    checks++; if (lat != 3) begin errors++; $display("FAIL dec_latency got %0d want 3", lat); end
    pop(8);
  endtask

  task automatic test_compare;
    logic [15:0] fo; logic co, eo, oo; int lat;
    issue(16, 16'h1234, 16'h1234, 4'b0110, 1'b0, 1'b0, fo, co, eo, oo, lat);
    checks++; if (fo !== 16'hFFFF) begin errors++; $display("FAIL cmp_eq_f got %h want ffff", fo); end
    checks++; if (eo !== 1'b1) begin errors++; $display("FAIL cmp_eq_a_eq_b got %b want 1", eo); end
    pop(16);
    issue(16, 16'h1235, 16'h1234, 4'b0110, 1'b0, 1'b0, fo, co, eo, oo, lat);
    checks++; if (fo !== 16'h0000) begin errors++; $display("FAIL cmp_ne_f got %h want 0000", fo); end
    checks++; if (eo !== 1'b0) begin errors++; $display("FAIL cmp_ne_a_eq_b got %b want 0", eo); end
    checks++; if (co !== 1'b1) begin errors++; $display("FAIL cmp_ne_c_out got %b want 1", co); end
    pop(16);
  endtask

  task automatic test_backpressure;
    logic [15:0] fo; logic co, eo, oo; int lat;
    issue(8, 16'h005A, 16'h00FF, 4'b0110, 1'b1, 1'b0, fo, co, eo, oo, lat);
    checks++; if (fo[7:0] !== 8'hA5) begin errors++; $display("FAIL bp_f got %h want a5", fo[7:0]); end
    checks++; if (co !== 1'b0) begin errors++; $display("FAIL bp_c_out got %b want 0", co); end
    iv8 = 1'b1; a8 = 8'h11; b8 = 8'h22; s = 4'b1001; m = 1'b0; c_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (ov8 !== 1'b1 || ir8 !== 1'b0 || f8 !== 8'hA5 || co8 !== 1'b0 || eq8 !== 1'b0)
        begin errors++; $display("FAIL bp_hold cycle %0d got ov=%b ir=%b f=%h c=%b eq=%b want 1 0 a5 0 0",
                                 i, ov8, ir8, f8, co8, eq8); end
    end
    iv8 = 1'b0;
    pop(8);
    checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0) begin errors++;
      $display("FAIL bp_release got ir=%b ov=%b want 1 0", ir8, ov8); end
  endtask

  task automatic test_ovf;
    logic [15:0] fo, ef; logic co, eo, oo, ec, ee, eov; int lat;
    model(8, 16'h007F, 16'h0001, 4'b1001, 1'b0, 1'b0, ef, ec, ee, eov);
    issue(8, 16'h007F, 16'h0001, 4'b1001, 1'b0, 1'b0, fo, co, eo, oo, lat);
    checks++; if (fo[7:0] !== 8'h80) begin errors++; $display("FAIL ovf_f got %h want 80", fo[7:0]); end
    checks++; if (oo !== eov) begin errors++; $display("FAIL ovf_flag got %b want %b", oo, eov); end
    pop(8);
  endtask

  task automatic test_reset_midrun;
    logic [15:0] fo, ef; logic co, eo, oo, ec, ee, eov; int lat;
    @(negedge clk);
    a16 = 16'hABCD; b16 = 16'h1111; s = 4'b1001; m = 1'b0; c_in = 1'b0; iv16 = 1'b1;
    @(posedge clk); #1; iv16 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    checks++; if (ir16 !== 1'b1 || ov16 !== 1'b0) begin errors++;
      $display("FAIL midrun_ctrl got ir=%b ov=%b want 1 0", ir16, ov16); end
    checks++; if (f16 !== 16'h0 || co16 !== 1'b0 || eq16 !== 1'b0 || of16 !== 1'b0) begin errors++;
      $display("FAIL midrun_outputs got f=%h c=%b eq=%b ovf=%b want 0", f16, co16, eq16, of16); end
    @(negedge clk); rst_n = 1'b1;
    model(16, 16'h8001, 16'h7FFF, 4'b0110, 1'b0, 1'b1, ef, ec, ee, eov);
    issue(16, 16'h8001, 16'h7FFF, 4'b0110, 1'b0, 1'b1, fo, co, eo, oo, lat);
    checks++; if (fo !== ef || co !== ec || oo !== eov) begin errors++;
      $display("FAIL midrun_next got f=%h c=%b ovf=%b want %h %b %b", fo, co, oo, ef, ec, eov); end
    pop(16);
  endtask

  task automatic test_random;
    logic [15:0] fo, ef, av, bv; logic co, eo, oo, ec, ee, eov, mv, cv; logic [3:0] sv;
    int lat, w;
    for (int n = 0; n < 60; n++) begin
      w  = ($urandom_range(0, 1) == 1) ? 16 : 8;
      av = 16'($urandom); bv = 16'($urandom);
      if (n % 7 == 0) bv = av;
      sv = 4'($urandom_range(0, 15)); mv = 1'($urandom); cv = 1'($urandom);
      if (n % 7 == 0) begin sv = 4'b0110; mv = 1'b0; cv = 1'b0; end
      model(w, av, bv, sv, mv, cv, ef, ec, ee, eov);
      issue(w, av, bv, sv, mv, cv, fo, co, eo, oo, lat);
      checks++;
      if (fo !== ef || co !== ec || eo !== ee || oo !== eov || lat != w / 4 + 1) begin
        errors++;
        $display("FAIL random w=%0d a=%h b=%h s=%b m=%b cin=%b got f=%h c=%b eq=%b ovf=%b lat=%0d want %h %b %b %b %0d",
                 w, av, bv, sv, mv, cv, fo, co, eo, oo, lat, ef, ec, ee, eov, w / 4 + 1);
      end
      pop(w);
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    test_reset;
    test_add_carry;
    test_dec_ripple;
    test_compare;
    test_backpressure;
    test_ovf;
    test_reset_midrun;
    test_random;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
